// File: rtl/mips_io_pkg.sv
// Shared definitions for the SYSCALL I/O responder: opcodes, input FSM
// states and the BCD-to-7-segment table (active-low, gfedcba).
package mips_io_pkg;

  localparam logic [5:0] OP_SYSCALL_IN  = 6'b110011;
  localparam logic [5:0] OP_SYSCALL_OUT = 6'b110111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } in_state_e;

  // Index n holds the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_TAB = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Non-decimal codes cannot come out of the converter; blank them anyway.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    if (d <= 4'd9) seg7 = SEG_TAB[d];
    else           seg7 = SEG_BLANK;
  endfunction

endpackage

// File: rtl/mips_syscall_io_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter. One shift per clock;
// a new load always restarts, so the most recent value wins. done pulses
// for one cycle once all DISP_W shifts are in, with bcd valid that cycle.
module bin2bcd_seq import mips_io_pkg::*; #(
  parameter int DISP_W = 16,
  parameter int NDIG   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DISP_W-1:0]   bin,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd
);

  localparam int CW = $clog2(DISP_W + 1);

  logic [DISP_W-1:0] sh;
  logic [4*NDIG-1:0] acc;
  logic [4*NDIG-1:0] adj;
  logic [4*NDIG-1:0] acc_nxt;
  logic [CW-1:0]     cnt;
  logic              busy;

  // Add-3 correction on every digit that is 5 or more, then shift in the next bit.
  always_comb begin
    adj = acc;
    for (int i = 0; i < NDIG; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_nxt = {adj[4*NDIG-2:0], sh[DISP_W-1]};
  end

  // Load/restart, shift while bits remain, retire after the done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      sh   <= bin;
      acc  <= '0;
      cnt  <= CW'(DISP_W);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        sh  <= {sh[DISP_W-2:0], 1'b0};
        acc <= acc_nxt;
        cnt <= cnt - 1'b1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done = busy && (cnt == '0);
  assign bcd  = acc;

endmodule

// File: rtl/mips_syscall_io.sv
// SYSCALL input/output responder. Input: freeze the datapath until the
// user confirms the switches with the pushbutton, then strobe the value
// to writeback. Output: convert the register value to decimal and show
// it on the 7-segment digits.
// Optional: define MIPS_SYSCALL_DEBOUNCE_EN to debounce the button over
// DEB_CYCLES clocks; otherwise the synchronized level is used directly.
module mips_syscall_io import mips_io_pkg::*; #(
  parameter int SW_W       = 16,
  parameter int DISP_W     = 16,
  parameter int NDIG       = 5,
  parameter int DEB_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op,
  input  logic [31:0]       reg_value,
  input  logic [SW_W-1:0]   sw,
  input  logic              btn_confirm,
  output logic              stall,
  output logic              in_valid,
  output logic [31:0]       in_data,
  output logic [7*NDIG-1:0] seg
);

  logic sync1, sync2;
  logic deb, deb_q, press;
  in_state_e state;

  // Two-flop synchronizer for the asynchronous pushbutton.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_confirm;
      sync2 <= sync1;
    end
  end

`ifdef MIPS_SYSCALL_DEBOUNCE_EN
  localparam int DCW = $clog2(DEB_CYCLES + 1);

  logic [DCW-1:0] deb_cnt;
  logic           deb_lvl;

  // Accept a new level only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      deb_lvl <= 1'b0;
    end else if (sync2 == deb_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DCW'(DEB_CYCLES - 1)) begin
      deb_cnt <= '0;
      deb_lvl <= sync2;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign deb = deb_lvl;
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES == 0);
  assign deb = sync2;
`endif

  // Registered rising-edge detect; a level held across WAIT entry gives no press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= 1'b0;
      press <= 1'b0;
    end else begin
      deb_q <= deb;
      press <= deb & ~deb_q;
    end
  end

  // Input FSM: only IDLE can start a transaction, so op still reading
  // SYSCALL-input during DONE does not retrigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      in_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (op == OP_SYSCALL_IN) state <= S_WAIT;
        S_WAIT: if (press) begin
          in_data <= 32'(sw);
          state   <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall    = !rst && (((state == S_IDLE) && (op == OP_SYSCALL_IN)) || (state == S_WAIT));
  assign in_valid = !rst && (state == S_DONE);

  logic                conv_done;
  logic [4*NDIG-1:0]   conv_bcd;
  logic                unused_rv;

  assign unused_rv = ^reg_value[31:DISP_W];

  bin2bcd_seq #(
    .DISP_W (DISP_W),
    .NDIG   (NDIG)
  ) u_conv (
    .clk  (clk),
    .rst  (rst),
    .load (op == OP_SYSCALL_OUT),
    .bin  (reg_value[DISP_W-1:0]),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  // Display holds the last finished number; every digit shown, no blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NDIG; i++) seg[7*i +: 7] <= SEG_ZERO;
    end else if (conv_done) begin
      for (int i = 0; i < NDIG; i++) seg[7*i +: 7] <= seg7(conv_bcd[4*i +: 4]);
    end
  end

endmodule

// File: tb/tb_mips_syscall_io.sv
// Bench for mips_syscall_io: a cycle-level behavioural model of the
// button path, input handshake and display, compared every cycle, plus
// directed literal expectations.
module tb_mips_syscall_io;

  localparam logic [5:0] OPI = 6'b110011;
  localparam logic [5:0] OPO = 6'b110111;
`ifdef MIPS_SYSCALL_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif
  localparam int LAT = 3 + DEB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  op = '0;
  logic [31:0] reg_value = '0;
  logic [15:0] sw = '0;
  logic        btn_confirm = 1'b0;
  logic        stall, in_valid;
  logic [31:0] in_data;
  logic [34:0] seg;

  int checks = 0;
  int failures = 0;

  mips_syscall_io #(.SW_W(16), .DISP_W(16), .NDIG(5), .DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .op(op), .reg_value(reg_value), .sw(sw),
    .btn_confirm(btn_confirm), .stall(stall), .in_valid(in_valid),
    .in_data(in_data), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b1000000; 1: pat = 7'b1111001; 2: pat = 7'b0100100;
      3: pat = 7'b0110000; 4: pat = 7'b0011001; 5: pat = 7'b0010010;
      6: pat = 7'b0000010; 7: pat = 7'b1111000; 8: pat = 7'b0000000;
      default: pat = 7'b0010000;
    endcase
  endfunction

  function automatic logic [34:0] segs(input int v);
    int p = 1;
    logic [34:0] r;
    for (int i = 0; i < 5; i++) begin
      r[7*i +: 7] = pat((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  logic [15:0] raw_h;   // raw_h[k] = button k cycles ago
  logic [15:0] deb_h;   // deb_h[k] = debounced level k cycles ago
  logic        mdeb;    // debounced level for the coming cycle
  int          phase;   // 0 idle, 1 waiting, 2 done
  logic [31:0] m_data;
  int          m_disp, pend_val, pend_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_h = '0; deb_h = '0; mdeb = 1'b0; phase = 0;
      m_data = '0; m_disp = 0; pend_val = 0; pend_cnt = 0;
    end else begin
      logic syn, dc, all_new, prs;
      raw_h = {raw_h[14:0], btn_confirm};
      syn = raw_h[2];
      if (DEB == 0) dc = syn;
      else begin
        dc = mdeb;
        all_new = 1'b1;
        for (int k = 0; k < DEB; k++) if (raw_h[2+k] == dc) all_new = 1'b0;
        if (all_new) mdeb = ~dc;
      end
      deb_h = {deb_h[14:0], dc};
      prs = deb_h[1] & ~deb_h[2];
      case (phase)
        0: if (op == OPI) phase = 1;
        1: if (prs) begin m_data = {16'h0, sw}; phase = 2; end
        default: phase = 0;
      endcase
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) m_disp = pend_val;
      end
      if (op == OPO) begin
        pend_val = int'(reg_value[15:0]);
        pend_cnt = 17;
      end
    end
  end

  // Compare DUT against the model mid-cycle, every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_stall", {63'h0, stall}, {63'h0, (phase == 0 && op == OPI) || phase == 1});
      chk("m_in_valid", {63'h0, in_valid}, {63'h0, phase == 2});
      chk("m_in_data", {32'h0, in_data}, {32'h0, m_data});
      chk("m_seg", {29'h0, seg}, {29'h0, segs(m_disp)});
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  localparam logic [34:0] SEG00000 = {5{7'b1000000}};
  localparam logic [34:0] SEG12345 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010};
  localparam logic [34:0] SEG00007 = {{4{7'b1000000}}, 7'b1111000};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // reset values, stall forced low even with the IN opcode present
    op = OPI;
    @(negedge clk);
    chk("rst_stall", {63'h0, stall}, 64'h0);
    chk("rst_in_valid", {63'h0, in_valid}, 64'h0);
    chk("rst_in_data", {32'h0, in_data}, 64'h0);
    chk("rst_seg", {29'h0, seg}, {29'h0, SEG00000});
    op = '0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) nxt();

    // basic input handshake, press 5 cycles after the op
    op = OPI; sw = 16'h002A;
    @(negedge clk) chk("in1_stall_rise", {63'h0, stall}, 64'h1);
    repeat (5) nxt();
    btn_confirm = 1'b1;
    repeat (LAT) nxt();
    @(negedge clk) chk("in1_stall_press", {63'h0, stall}, 64'h1);
    nxt();
    @(negedge clk);
    chk("in1_valid", {63'h0, in_valid}, 64'h1);
    chk("in1_data", {32'h0, in_data}, 64'h2A);
    chk("in1_stall_done", {63'h0, stall}, 64'h0);
    nxt(); op = '0; btn_confirm = 1'b0;
    @(negedge clk) chk("in1_valid_drop", {63'h0, in_valid}, 64'h0);

    // button already held when the op arrives: must release and re-press
    repeat (LAT + 3) nxt();
    btn_confirm = 1'b1;
    repeat (LAT + 3) nxt();
    sw = 16'h1234; op = OPI;
    repeat (10) nxt();
    @(negedge clk);
    chk("in2_held_stall", {63'h0, stall}, 64'h1);
    chk("in2_held_noval", {63'h0, in_valid}, 64'h0);
    nxt(); btn_confirm = 1'b0;
    repeat (LAT + 3) nxt();
    btn_confirm = 1'b1;
    repeat (LAT + 1) nxt();
    @(negedge clk);
    chk("in2_valid", {63'h0, in_valid}, 64'h1);
    chk("in2_data", {32'h0, in_data}, 64'h1234);
    nxt(); op = '0; btn_confirm = 1'b0;
    repeat (LAT + 3) nxt();

    // output conversion of 12345
    op = OPO; reg_value = 32'h0001_3039;
    @(negedge clk) chk("out1_no_stall", {63'h0, stall}, 64'h0);
    nxt(); op = '0; reg_value = '0;
    repeat (16) nxt();
    @(negedge clk) chk("out1_seg_hold", {29'h0, seg}, {29'h0, SEG00000});
    nxt();
    @(negedge clk) chk("out1_seg_12345", {29'h0, seg}, {29'h0, SEG12345});

    // back-to-back OUT: latest value wins, 65535 never shown
    nxt(); op = OPO; reg_value = 32'h0000_FFFF;
    nxt(); reg_value = 32'h0000_0007;
    nxt(); op = '0; reg_value = '0;
    repeat (20) nxt();
    @(negedge clk) chk("out2_seg_00007", {29'h0, seg}, {29'h0, SEG00007});

`ifdef MIPS_SYSCALL_DEBOUNCE_EN
    // short glitch ignored, 6-cycle press accepted
    begin
      bit got = 1'b0;
      nxt(); op = OPI; sw = 16'h00C3;
      repeat (3) nxt();
      btn_confirm = 1'b1;
      repeat (2) nxt();
      btn_confirm = 1'b0;
      repeat (12) nxt();
      @(negedge clk);
      chk("deb_glitch_stall", {63'h0, stall}, 64'h1);
      chk("deb_glitch_noval", {63'h0, in_valid}, 64'h0);
      nxt(); btn_confirm = 1'b1;
      repeat (6) nxt();
      btn_confirm = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (in_valid) begin
          got = 1'b1;
          chk("deb_data", {32'h0, in_data}, 64'hC3);
        end
        nxt();
      end
      op = '0;
      chk("deb_press_done", {63'h0, got}, 64'h1);
      repeat (LAT + 3) nxt();
    end
`endif

    // asynchronous reset during WAIT
    op = OPI; sw = 16'h0005;
    repeat (3) nxt();
    @(negedge clk) chk("rst_wait_stall", {63'h0, stall}, 64'h1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("arst_stall", {63'h0, stall}, 64'h0);
    chk("arst_in_valid", {63'h0, in_valid}, 64'h0);
    chk("arst_in_data", {32'h0, in_data}, 64'h0);
    chk("arst_seg", {29'h0, seg}, {29'h0, SEG00000});
    @(posedge clk); #1 rst = 1'b0; op = '0;
    repeat (6) nxt();
    @(negedge clk) chk("post_rst_stall", {63'h0, stall}, 64'h0);

    nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_syscall_io.md
# mips_syscall_io

Responder for the processor's two SYSCALL opcodes. On SYSCALL-input it freezes the datapath, waits for the user to confirm a switch value with a pushbutton, then hands that value to register writeback. On SYSCALL-output it captures a register value and converts it to decimal with a sequential converter. It then drives the 7-segment displays. It sits beside the control unit, decodes `op` itself, and its `stall` gates the PC/register-file clock enable.

## Interface
Parameters:
- `SW_W`, 16: switch bank width; zero-extended to 32 bits.
- `DISP_W`, 16: number of low bits of the register value that are displayed.
- `NDIG`, 5: decimal digits shown; must satisfy 10^NDIG > 2^DISP_W.
- `DEB_CYCLES`, 500000: debounce stability window, in clocks.

Ports (clock and reset first):
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `op`, in, 6: current instruction opcode.
- `reg_value`, in, 32: rs read data, used for output.
- `sw`, in, SW_W: raw user switches.
- `btn_confirm`, in, 1: raw pushbutton, active-high.
- `stall`, out, 1: hold PC and register file while high.
- `in_valid`, out, 1: one-cycle strobe meaning `in_data` must be written back this cycle.
- `in_data`, out, 32: captured switch value.
- `seg`, out, 7*NDIG: active-low segments in gfedcba order; digit 0 (least significant) is in bits [6:0].

## Operation
- `btn_confirm` passes through a 2-flop synchronizer, then the debouncer (see Configuration), then a rising-edge detector, producing `press` (one cycle).
- Input FSM has three states.
  - IDLE: if `op`==OP_SYSCALL_IN, go to WAIT.
  - WAIT: on `press`, load `in_data` <= zero-extended `sw`, then go to DONE.
  - DONE: go to IDLE unconditionally.
- `stall` is combinational: (IDLE && `op`==OP_SYSCALL_IN) || WAIT. It is forced to 0 while `rst`=1.
- `in_valid` = (state==DONE). In DONE, `op` still reads OP_SYSCALL_IN, but this does not retrigger because the FSM only leaves IDLE from IDLE.
- `press` is ignored outside WAIT. A button already held when WAIT is entered gives no edge; the user must release and press again.
- Output path: when `op`==OP_SYSCALL_OUT in any cycle, `reg_value[DISP_W-1:0]` is loaded into converter `bin2bcd_seq` (double-dabble, one shift per cycle).
  - An OUT arriving while a conversion is busy restarts the conversion with the new value; the latest value wins.
  - `seg` holds the previous number until a conversion completes.
  - All NDIG digits are shown, with no leading-zero blanking.
- The output path never asserts `stall`.

## Timing
- Reset values:
  - FSM in IDLE, `stall`=0, `in_valid`=0, `in_data`=0.
  - Converter idle.
  - Every digit of `seg` shows "0" (7'b1000000).
- Input path:
  - `stall` rises in the same cycle OP_SYSCALL_IN appears.
  - `in_data` is valid, `in_valid`=1 and `stall`=0 exactly in the cycle after the `press` cycle.
  - `press` comes 3 cycles after a clean raw rise without debounce, and DEB_CYCLES+3 cycles with debounce.
- Output path: OUT in cycle T.
  - The converter loads on the edge ending T.
  - It shifts on the edges ending T+1 … T+DISP_W.
  - `seg` updates on the edge ending T+DISP_W+1.
- Reset mid-operation (any state, mid-conversion): outputs return to their reset values immediately. No `in_valid` pulse is produced, and any conversion in flight is discarded.

## Configuration
- `MIPS_SYSCALL_DEBOUNCE_EN` defined: the synchronized button must be stable at a new level for DEB_CYCLES consecutive cycles before the debounced level changes. A counter resets on every mismatch.
- Undefined: the debounced level equals the synchronized level, and DEB_CYCLES is unused.

## Structure
- Shared package `mips_io_pkg` holds:
  - OP_SYSCALL_IN = 6'b110011 and OP_SYSCALL_OUT = 6'b110111.
  - The input FSM state enum.
  - The BCD-to-7-segment constant table.
- Sub-module `bin2bcd_seq`.
  - Parameters: DISP_W, NDIG.
  - Ports: `load`, `bin`, `done`, `bcd`.
  - It holds the shift register and the cycle counter.
- The top level holds the synchronizer, debouncer, input FSM and segment decode.

## Test plan
- Reset: assert `rst` → `stall`=0, `in_valid`=0, `in_data`=0, `seg` = 5×7'b1000000.
- `op`=110011, `sw`=16'h002A, press the button 5 cycles later (debounce off) → `stall`=1 from the op cycle through the press+0 cycle. `in_valid`=1 for exactly one cycle with `in_data`=32'h0000002A, and `stall`=0 in that cycle.
- Button held high before `op`=110011 → FSM stays in WAIT with `stall`=1. Release then press → completes normally.
- `op`=110111, `reg_value`=32'h00013039 → digits read 1,2,3,4,5 exactly 17 cycles later, and `stall` stays 0 throughout.
- OUT with 16'hFFFF, then OUT with 7 in the next cycle → `seg` goes directly to 00007 and never shows 65535.
- With `MIPS_SYSCALL_DEBOUNCE_EN` and DEB_CYCLES=4: a 2-cycle glitch is ignored, and a 6-cycle press completes the input. Asserting `rst` during WAIT → `stall` drops asynchronously, and no `in_valid` pulse occurs.
